pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 120 ++++++++++++
 tb/tb_pwm_capture.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and duty percent of an asynchronous PWM input,
// with a stuck-input timeout that forces duty to 0 or 100.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q, rise, fall;
  logic [CNT_W-1:0] cnt_q, cnt_d, h_lat_q, h_lat_d;
  logic busy_q, sat, done, timeout, start, ge;
  logic [2:0] it_q;
  logic [CNT_W-1:0] rem_q, den_q, dh_q, rem_nx;
  logic [6:0] num_q, quo_nx;
  logic [5:0] quo_q;
  logic [CNT_W:0] trial, diff;
  logic [CNT_W+6:0] num_full;
  logic [CNT_W-1:0] high_q, period_q;
  logic [6:0] duty_q;
  logic valid_q, stuck_q, level_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
  assign sat = cnt_q == TMO;
  assign done = busy_q && it_q == 3'd6;
  assign timeout = sat && !stuck_q && !done;
  assign start = state_q == LOW && rise && !busy_q && !timeout;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = timeout ? IDLE : rise ? HIGH : (fall && state_q == HIGH) ? LOW : state_q;
  end
  // In IDLE any edge restarts the count so a frozen input still times out.
  always_comb begin
    cnt_d = (rise || (fall && state_q == IDLE) || (sat && done)) ? CNT_W'(1) :
            sat ? cnt_q : cnt_q + CNT_W'(1);
    h_lat_d = (state_q == HIGH && fall) ? cnt_q : h_lat_q;
  end
  // Restoring divide of h*100 by p; h <= p keeps the quotient within 7 bits.
  always_comb begin
    num_full = {7'd0, h_lat_q} * (CNT_W+7)'(100);
    trial = {rem_q, num_q[6]};
    diff = trial - {1'b0, den_q};
    ge = trial >= {1'b0, den_q};
    rem_nx = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    quo_nx = {quo_q, ge};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_q, s2_q, s3_q} <= '0;
      cnt_q <= '0;
      h_lat_q <= '0;
      busy_q <= 1'b0;
      it_q <= '0;
      rem_q <= '0;
      num_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      dh_q <= '0;
      high_q <= '0;
      period_q <= '0;
      duty_q <= '0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      {s1_q, s2_q, s3_q} <= {pwm_in, s1_q, s2_q};
      cnt_q <= cnt_d;
      h_lat_q <= h_lat_d;
      if (start) begin
        busy_q <= 1'b1;
        it_q <= '0;
        rem_q <= num_full[CNT_W+6:7];
        num_q <= num_full[6:0];
        quo_q <= '0;
        den_q <= cnt_q;
        dh_q <= h_lat_q;
      end else if (busy_q) begin
        busy_q <= !done;
        it_q <= it_q + 3'd1;
        rem_q <= rem_nx;
        num_q <= {num_q[5:0], 1'b0};
        quo_q <= quo_nx[5:0];
      end
      if (done) begin
        high_q <= dh_q;
        period_q <= den_q;
        duty_q <= quo_nx;
        valid_q <= 1'b1;
        stuck_q <= 1'b0;
      end else if (timeout) begin
        duty_q <= s2_q ? 7'd100 : 7'd0;
        valid_q <= 1'b1;
        stuck_q <= 1'b1;
        level_q <= s2_q;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(rise && fall));
  assign high_cnt = high_q;
  assign period_cnt = period_q;
  assign duty_pct = duty_q;
  assign valid = valid_q;
  assign stuck = stuck_q;
  assign stuck_level = level_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture measurement, discard, reset and timeout behaviour.
module tb_pwm_capture;
  logic clk = 1'b0, rst = 1'b1, pwm_in = 1'b0;
  logic [15:0] high_cnt, period_cnt;
  logic [6:0] duty_pct;
  logic valid, stuck, stuck_level;
  int checks = 0, failures = 0, vcount = 0, v0 = 0;

  // Short timeout keeps the stuck scenarios within a small cycle budget.
  pwm_capture #(.CNT_W(16), .TIMEOUT(5000)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .high_cnt(high_cnt), .period_cnt(period_cnt),
    .duty_pct(duty_pct), .valid(valid), .stuck(stuck), .stuck_level(stuck_level));

  always #5 clk = ~clk;
  always @(posedge clk) if (valid) vcount <= vcount + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  // Call with pwm_in just raised (closing rise); holds pwm_in high for 11 cycles.
  task automatic report(input string tag, input int h, input int p, input int d);
    tick(9);
    chk({tag, "_early"}, 32'(valid), 0);
    tick(1);
    chk({tag, "_valid"}, 32'(valid), 1);
    chk({tag, "_high"}, 32'(high_cnt), h);
    chk({tag, "_period"}, 32'(period_cnt), p);
    chk({tag, "_duty"}, 32'(duty_pct), d);
    chk({tag, "_stuck"}, 32'(stuck), 0);
    tick(1);
    chk({tag, "_pulse1"}, 32'(valid), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_high"}, 32'(high_cnt), 0);
    chk({tag, "_period"}, 32'(period_cnt), 0);
    chk({tag, "_duty"}, 32'(duty_pct), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_stuck"}, 32'(stuck), 0);
    chk({tag, "_level"}, 32'(stuck_level), 0);
  endtask

  initial begin
    do_reset();
    chk_zero("rst");
    // 4000/1000 repeated
    v0 = vcount;
    pwm_in = 1; tick(1000); pwm_in = 0; tick(3000);
    chk("s1_first_rise", 32'(vcount - v0), 0);
    pwm_in = 1; report("s1a", 1000, 4000, 25);
    tick(989); pwm_in = 0; tick(3000);
    chk("s1_one_valid", 32'(vcount - v0), 1);
    pwm_in = 1; report("s1b", 1000, 4000, 25);
    // reset mid-HIGH, then during a divide
    tick(500); rst = 1; pwm_in = 0; tick(2); rst = 0;
    chk_zero("s4_midhigh");
    v0 = vcount;
    pwm_in = 1; tick(1000); pwm_in = 0; tick(3000);
    pwm_in = 1; tick(5); rst = 1; pwm_in = 0; tick(2); rst = 0; tick(10);
    chk("s4_abort_valid", 32'(vcount - v0), 0);
    chk_zero("s4_abort");
    pwm_in = 1; tick(1000); pwm_in = 0; tick(3000);
    chk("s4_one_rise", 32'(vcount - v0), 0);
    pwm_in = 1; report("s4", 1000, 4000, 25);
    // 4000 then 5-cycle period, then 4000/2000
    do_reset();
    pwm_in = 1; tick(1000); pwm_in = 0; tick(3000);
    pwm_in = 1; tick(2); pwm_in = 0; tick(3); pwm_in = 1; tick(5);
    chk("s5_valid", 32'(valid), 1);
    chk("s5_duty", 32'(duty_pct), 25);
    chk("s5_high", 32'(high_cnt), 1000);
    tick(1);
    v0 = vcount;
    tick(10);
    chk("s5_discard", 32'(vcount - v0), 0);
    chk("s5_keep_duty", 32'(duty_pct), 25);
    chk("s5_keep_period", 32'(period_cnt), 4000);
    tick(1984); pwm_in = 0; tick(2000);
    pwm_in = 1; report("s5_next", 2000, 4000, 50);
    // high 1 / period 3 shows truncation
    do_reset();
    pwm_in = 1; tick(1); pwm_in = 0; tick(2);
    pwm_in = 1; report("s2_trunc", 1, 3, 33);
    pwm_in = 0; tick(9);
    pwm_in = 1; report("s2_p20", 11, 20, 55);
    // stuck high
    do_reset();
    v0 = vcount;
    pwm_in = 1; tick(5002);
    chk("s3_pre_valid", 32'(valid), 0);
    chk("s3_pre_stuck", 32'(stuck), 0);
    tick(1);
    chk("s3_valid", 32'(valid), 1);
    chk("s3_stuck", 32'(stuck), 1);
    chk("s3_level", 32'(stuck_level), 1);
    chk("s3_duty", 32'(duty_pct), 100);
    chk("s3_high", 32'(high_cnt), 0);
    chk("s3_period", 32'(period_cnt), 0);
    tick(997);
    chk("s3_once", 32'(vcount - v0), 1);
    pwm_in = 0; tick(2000); pwm_in = 1; tick(2000); pwm_in = 0; tick(2000);
    chk("s3_still_stuck", 32'(stuck), 1);
    chk("s3_no_extra", 32'(vcount - v0), 1);
    pwm_in = 1; report("s3_resume", 2000, 4000, 50);
    // stuck low from reset
    do_reset();
    v0 = vcount;
    tick(5000);
    chk("s6_pre_stuck", 32'(stuck), 0);
    tick(1);
    chk("s6_valid", 32'(valid), 1);
    chk("s6_stuck", 32'(stuck), 1);
    chk("s6_level", 32'(stuck_level), 0);
    chk("s6_duty", 32'(duty_pct), 0);
    tick(100);
    chk("s6_once", 32'(vcount - v0), 1);
    chk("s6_hold", 32'(stuck), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
